// File: rtl/qspi_flash_model.sv
// Read-only QSPI flash mock serving `buffer` via 0x03/0x0B, plus 0x6B/0xEB when
// QSPI_MODEL_QUAD_EN is defined. SPI pins are oversampled on clk.
module qspi_flash_model #(
  parameter int unsigned BUFFER_SIZE = 256,
  parameter int unsigned ADDR_BITS   = 24,
  parameter int unsigned DUMMY_FAST  = 8,
  parameter int unsigned DUMMY_QIO   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BUFFER_SIZE-1:0] buffer,
  input  logic                   cs,
  input  logic                   sclk,
  input  logic [3:0]             dq_i,
  output logic [3:0]             dq_o,
  output logic [3:0]             dq_oe,
  output logic                   busy,
  output logic                   oob,
  output logic [31:0]            bytes_served
);
  localparam int unsigned NBYTES = BUFFER_SIZE / 8;

`ifdef QSPI_MODEL_QUAD_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
`endif
  state_t state, state_nx;

  logic                 sclk_q, cs_q;
  logic [3:0]           dq_q;
  logic                 rise, fall, cs_fall;
  logic [6:0]           cmd_sr;
  logic [7:0]           cmd_next;
  logic [7:0]           cnt, addr_last, dummy_n, nx_dummy;
  logic                 quad_addr, quad_data, nx_quad_addr, nx_quad_data, known_cmd;
  logic [ADDR_BITS-1:0] addr;
  logic                 addr_oob;
  logic [7:0]           fetch, load_byte, shreg;
  logic [2:0]           dcnt;

  assign rise      = !sclk_q && sclk && !cs;
  assign fall      = sclk_q && !sclk && !cs;
  assign cs_fall   = cs_q && !cs;
  assign cmd_next  = {cmd_sr, dq_q[0]};
  assign addr_last = quad_addr ? 8'(ADDR_BITS / 4 - 1) : 8'(ADDR_BITS - 1);
  assign addr_oob  = 32'(addr) >= NBYTES;
  assign load_byte = addr_oob ? 8'h00 : fetch;

  always_comb begin
    fetch = '0;
    for (int unsigned i = 0; i < NBYTES; i++)
      if (addr == ADDR_BITS'(i)) fetch = buffer[8*i +: 8];
  end

  always_comb begin
    known_cmd    = 1'b1;
    nx_quad_addr = 1'b0;
    nx_quad_data = 1'b0;
    nx_dummy     = '0;
    case (cmd_next)
      8'h03: ;
      8'h0B: nx_dummy = 8'(DUMMY_FAST);
`ifdef QSPI_MODEL_QUAD_EN
      8'h6B: begin nx_quad_data = 1'b1; nx_dummy = 8'(DUMMY_FAST); end
      8'hEB: begin nx_quad_addr = 1'b1; nx_quad_data = 1'b1; nx_dummy = 8'(DUMMY_QIO); end
`endif
      default: known_cmd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs) state_nx = IDLE;
    else begin
      case (state)
        IDLE:  if (cs_fall) state_nx = CMD;
        CMD:   if (rise && cnt == 8'd7) state_nx = known_cmd ? ADDR : IGNORE;
        ADDR:  if (rise && cnt == addr_last) begin
`ifdef QSPI_MODEL_QUAD_EN
                 if (quad_addr)            state_nx = MODE;
                 else
`endif
                 if (dummy_n == '0)        state_nx = DATA;
                 else                      state_nx = DUMMY;
               end
`ifdef QSPI_MODEL_QUAD_EN
        MODE:  if (rise && cnt == 8'd1) state_nx = (dummy_n == '0) ? DATA : DUMMY;
`endif
        DUMMY: if (rise && cnt == dummy_n - 8'd1) state_nx = DATA;
        default: ;
      endcase
    end
  end

  always_comb busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_q       <= 1'b0;
      cs_q         <= 1'b0;
      dq_q         <= '0;
      cmd_sr       <= '0;
      cnt          <= '0;
      quad_addr    <= 1'b0;
      quad_data    <= 1'b0;
      dummy_n      <= '0;
      addr         <= '0;
      shreg        <= '0;
      dcnt         <= '0;
      dq_o         <= '0;
      dq_oe        <= '0;
      oob          <= 1'b0;
      bytes_served <= '0;
    end else begin
      sclk_q <= sclk;
      cs_q   <= cs;
      dq_q   <= dq_i;
      if (cs) begin
        cnt   <= '0;
        dcnt  <= '0;
        dq_oe <= '0;
      end else begin
        if (state != DATA) begin
          dq_oe <= '0;
          dcnt  <= '0;
        end
        if (rise && state != IDLE && state != DATA && state != IGNORE)
          cnt <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
        if (rise && state == CMD) begin
          cmd_sr <= cmd_next[6:0];
          if (cnt == 8'd7) begin
            quad_addr <= nx_quad_addr;
            quad_data <= nx_quad_data;
            dummy_n   <= nx_dummy;
          end
        end
        if (rise && state == ADDR)
          addr <= quad_addr ? {addr[ADDR_BITS-5:0], dq_q} : {addr[ADDR_BITS-2:0], dq_q[0]};
        // dcnt counts falls left in the current byte; zero means fetch a new one
        if (fall && state == DATA) begin
          dq_oe <= quad_data ? 4'b1111 : 4'b0010;
          if (dcnt == '0) begin
            addr         <= addr + 1'b1;
            bytes_served <= bytes_served + 32'd1;
            if (addr_oob) oob <= 1'b1;
            if (quad_data) begin
              dq_o  <= load_byte[7:4];
              shreg <= {load_byte[3:0], 4'b0000};
              dcnt  <= 3'd1;
            end else begin
              dq_o  <= {2'b00, load_byte[7], 1'b0};
              shreg <= {load_byte[6:0], 1'b0};
              dcnt  <= 3'd7;
            end
          end else begin
            if (quad_data) begin
              dq_o  <= shreg[7:4];
              shreg <= {shreg[3:0], 4'b0000};
            end else begin
              dq_o  <= {2'b00, shreg[7], 1'b0};
              shreg <= {shreg[6:0], 1'b0};
            end
            dcnt <= dcnt - 3'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_qspi_flash_model.sv
// Scoreboard bench for qspi_flash_model: 8-byte image, SCLK = clk/8, mode 0.
module tb_qspi_flash_model;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic [3:0]  dq_i = '0;
  logic [63:0] buffer = {32'hFFDFF0EF, 32'hABCDE137};
  logic [3:0]  dq_o, dq_oe;
  logic        busy, oob;
  logic [31:0] bytes_served;

  int total = 0;
  int bad = 0;
  int exp_served = 0;
  logic [7:0] sb[$];

  qspi_flash_model #(.BUFFER_SIZE(64), .ADDR_BITS(24), .DUMMY_FAST(8), .DUMMY_QIO(4)) dut (
    .clk(clk), .rst(rst), .buffer(buffer), .cs(cs), .sclk(sclk), .dq_i(dq_i),
    .dq_o(dq_o), .dq_oe(dq_oe), .busy(busy), .oob(oob), .bytes_served(bytes_served)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [7:0] model_byte(input int unsigned a);
    logic [63:0] img;
    img = buffer;
    return (a < 8) ? img[8*a +: 8] : 8'h00;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_in(input logic [3:0] v);
    dq_i = v;
    clks(4); sclk = 1'b1;
    clks(4); sclk = 1'b0;
  endtask

  task automatic pulse();
    sclk = 1'b1; clks(4); sclk = 1'b0;
  endtask

  task automatic begin_txn();
    cs = 1'b0; clks(4);
  endtask

  task automatic end_txn();
    clks(4); cs = 1'b1; clks(4);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) bit_in({3'b000, c[i]});
  endtask

  task automatic send_addr(input logic [23:0] a, input bit quad);
    if (quad) for (int i = 5; i >= 0; i--) bit_in(a[4*i +: 4]);
    else      for (int i = 23; i >= 0; i--) bit_in({3'b000, a[i]});
  endtask

  // First bit is already on the pins from the preceding fall.
  task automatic read_byte(input bit quad, output logic [7:0] b, output logic [3:0] oe);
    int n;
    n = quad ? 2 : 8;
    b = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) pulse();
      clks(4);
      b  = quad ? {b[3:0], dq_o} : {b[6:0], dq_o[1]};
      oe = dq_oe;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cs = 1'b1; clks(5);
    rst = 1'b1; clks(2);
    total++; if (dq_oe !== 4'h0)         begin bad++; $display("FAIL reset_dq_oe got=%h exp=0", dq_oe); end
    total++; if (dq_o !== 4'h0)          begin bad++; $display("FAIL reset_dq_o got=%h exp=0", dq_o); end
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (oob !== 1'b0)           begin bad++; $display("FAIL reset_oob got=%b exp=0", oob); end
    total++; if (bytes_served !== 32'd0) begin bad++; $display("FAIL reset_bytes got=%0d exp=0", bytes_served); end
  endtask

  task automatic test_read03();
    logic [7:0] got, exp;
    logic [3:0] oe;
    for (int k = 0; k < 8; k++) sb.push_back(model_byte(k));
    begin_txn();
    send_cmd(8'h03);
    send_addr(24'h000000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) pulse();
      read_byte(1'b0, got, oe);
      exp = sb.pop_front();
      total++; if (got !== exp)     begin bad++; $display("FAIL read03_byte%0d got=%h exp=%h", k, got, exp); end
      total++; if (oe !== 4'b0010)  begin bad++; $display("FAIL read03_oe%0d got=%h exp=2", k, oe); end
    end
    exp_served += 8;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL read03_busy got=%b exp=1", busy); end
    end_txn();
    total++; if (bytes_served !== 32'(exp_served)) begin bad++; $display("FAIL read03_served got=%0d exp=%0d", bytes_served, exp_served); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL read03_idle_busy got=%b exp=0", busy); end
    total++; if (dq_oe !== 4'h0)  begin bad++; $display("FAIL read03_idle_oe got=%h exp=0", dq_oe); end
  endtask

  task automatic test_fast_read();
    logic [7:0] got, exp;
    logic [3:0] oe, oe_or;
    for (int k = 0; k < 2; k++) sb.push_back(model_byte(4 + k));
    begin_txn();
    send_cmd(8'h0B);
    send_addr(24'h000004, 1'b0);
    oe_or = '0;
    for (int d = 0; d < 8; d++) begin
      clks(2);
      oe_or |= dq_oe;
      bit_in(4'h0);
    end
    total++; if (oe_or !== 4'h0) begin bad++; $display("FAIL fast_dummy_oe got=%h exp=0", oe_or); end
    for (int k = 0; k < 2; k++) begin
      if (k > 0) pulse();
      read_byte(1'b0, got, oe);
      exp = sb.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL fast_byte%0d got=%h exp=%h", k, got, exp); end
    end
    exp_served += 2;
    end_txn();
    total++; if (bytes_served !== 32'(exp_served)) begin bad++; $display("FAIL fast_served got=%0d exp=%0d", bytes_served, exp_served); end
  endtask

`ifdef QSPI_MODEL_QUAD_EN
  task automatic test_quad();
    logic [7:0] got, exp;
    logic [3:0] oe, oe_or;
    for (int k = 0; k < 3; k++) sb.push_back(model_byte(1 + k));
    begin_txn();
    send_cmd(8'hEB);
    send_addr(24'h000001, 1'b1);
    bit_in(4'hF); bit_in(4'hF);
    oe_or = '0;
    for (int d = 0; d < 4; d++) begin
      clks(2);
      oe_or |= dq_oe;
      bit_in(4'h0);
    end
    total++; if (oe_or !== 4'h0) begin bad++; $display("FAIL qio_dummy_oe got=%h exp=0", oe_or); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) pulse();
      read_byte(1'b1, got, oe);
      exp = sb.pop_front();
      total++; if (got !== exp)    begin bad++; $display("FAIL qio_byte%0d got=%h exp=%h", k, got, exp); end
      total++; if (oe !== 4'hF)    begin bad++; $display("FAIL qio_oe%0d got=%h exp=f", k, oe); end
    end
    exp_served += 3;
    end_txn();
    for (int k = 0; k < 2; k++) sb.push_back(model_byte(k));
    begin_txn();
    send_cmd(8'h6B);
    send_addr(24'h000000, 1'b0);
    for (int d = 0; d < 8; d++) bit_in(4'h0);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) pulse();
      read_byte(1'b1, got, oe);
      exp = sb.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL qout_byte%0d got=%h exp=%h", k, got, exp); end
    end
    exp_served += 2;
    end_txn();
    total++; if (bytes_served !== 32'(exp_served)) begin bad++; $display("FAIL quad_served got=%0d exp=%0d", bytes_served, exp_served); end
  endtask
`else
  task automatic test_quad();
    logic [7:0] cmds [2];
    logic [3:0] oe_or;
    cmds = '{8'hEB, 8'h6B};
    for (int c = 0; c < 2; c++) begin
      begin_txn();
      send_cmd(cmds[c]);
      oe_or = '0;
      for (int d = 0; d < 12; d++) begin
        bit_in(4'hF);
        clks(2);
        oe_or |= dq_oe;
      end
      total++; if (oe_or !== 4'h0) begin bad++; $display("FAIL noquad_oe cmd=%h got=%h exp=0", cmds[c], oe_or); end
      total++; if (busy !== 1'b1)  begin bad++; $display("FAIL noquad_busy cmd=%h got=%b exp=1", cmds[c], busy); end
      end_txn();
    end
    total++; if (bytes_served !== 32'(exp_served)) begin bad++; $display("FAIL noquad_served got=%0d exp=%0d", bytes_served, exp_served); end
  endtask
`endif

  task automatic test_abort();
    logic [7:0] got, exp;
    logic [3:0] oe, oe_or;
    begin_txn();
    send_cmd(8'h03);
    for (int i = 0; i < 10; i++) bit_in({3'b000, 1'(i % 2)});
    end_txn();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    sb.push_back(model_byte(0));
    begin_txn();
    send_cmd(8'h03);
    send_addr(24'h000000, 1'b0);
    read_byte(1'b0, got, oe);
    exp = sb.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL abort_reread got=%h exp=%h", got, exp); end
    exp_served += 1;
    end_txn();
    begin_txn();
    send_cmd(8'h9F);
    oe_or = '0;
    for (int d = 0; d < 16; d++) begin
      bit_in(4'h0);
      clks(2);
      oe_or |= dq_oe;
    end
    total++; if (oe_or !== 4'h0) begin bad++; $display("FAIL unknown_oe got=%h exp=0", oe_or); end
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL unknown_busy got=%b exp=1", busy); end
    end_txn();
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL unknown_release got=%b exp=0", busy); end
    total++; if (bytes_served !== 32'(exp_served)) begin bad++; $display("FAIL abort_served got=%0d exp=%0d", bytes_served, exp_served); end
  endtask

  task automatic test_oob();
    logic [7:0] got, exp;
    logic [3:0] oe;
    for (int k = 0; k < 4; k++) sb.push_back(model_byte(6 + k));
    begin_txn();
    send_cmd(8'h03);
    send_addr(24'h000006, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) pulse();
      read_byte(1'b0, got, oe);
      exp = sb.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL oob_byte%0d got=%h exp=%h", k, got, exp); end
      if (k == 1) begin
        total++; if (oob !== 1'b0) begin bad++; $display("FAIL oob_early got=%b exp=0", oob); end
      end
      if (k == 2) begin
        total++; if (oob !== 1'b1) begin bad++; $display("FAIL oob_set got=%b exp=1", oob); end
      end
    end
    exp_served += 4;
    end_txn();
    sb.push_back(model_byte(0));
    begin_txn();
    send_cmd(8'h03);
    send_addr(24'h000000, 1'b0);
    read_byte(1'b0, got, oe);
    exp = sb.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL oob_next_byte got=%h exp=%h", got, exp); end
    exp_served += 1;
    end_txn();
    total++; if (oob !== 1'b1) begin bad++; $display("FAIL oob_sticky got=%b exp=1", oob); end
    total++; if (bytes_served !== 32'(exp_served)) begin bad++; $display("FAIL oob_served got=%0d exp=%0d", bytes_served, exp_served); end
  endtask

  task automatic test_reset_midway();
    logic [7:0] got, exp;
    logic [3:0] oe;
    begin_txn();
    for (int i = 0; i < 4; i++) bit_in(4'h0);
    rst = 1'b0; clks(2); rst = 1'b1;
    exp_served = 0;
    bit_in(4'h0); bit_in(4'h0); bit_in(4'h1); bit_in(4'h1);
    send_addr(24'h000000, 1'b0);
    for (int d = 0; d < 8; d++) bit_in(4'h0);
    clks(2);
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (dq_oe !== 4'h0) begin bad++; $display("FAIL midrst_oe got=%h exp=0", dq_oe); end
    total++; if (oob !== 1'b0)   begin bad++; $display("FAIL midrst_oob got=%b exp=0", oob); end
    total++; if (bytes_served !== 32'(exp_served)) begin bad++; $display("FAIL midrst_served got=%0d exp=%0d", bytes_served, exp_served); end
    end_txn();
    sb.push_back(model_byte(3));
    begin_txn();
    send_cmd(8'h03);
    send_addr(24'h000003, 1'b0);
    read_byte(1'b0, got, oe);
    exp = sb.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL midrst_after got=%h exp=%h", got, exp); end
    exp_served += 1;
    end_txn();
    total++; if (bytes_served !== 32'(exp_served)) begin bad++; $display("FAIL midrst_after_served got=%0d exp=%0d", bytes_served, exp_served); end
  endtask

  initial begin
    test_reset();
    test_read03();
    test_fast_read();
    test_quad();
    test_abort();
    test_oob();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
